// File: rtl/reg_file_param.sv
// Parametrised register file: DMAR (index 0), DMDR (index 1), general registers R0..Rn.
// It supports clear and C-bus writes, pipelined memory loads into DMDR, and DMAR post-increment.
module reg_file_param #(
  parameter int DW       = 19,
  parameter int NREG     = 14,
  parameter int SELW     = 4,
  parameter int MDW      = 8,
  parameter int MEM_LAT  = 2,
  parameter int INC_STEP = 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            clr_en,
  input  logic [SELW-1:0] clr_sel,
  input  logic            c_en,
  input  logic [SELW-1:0] c_sel,
  input  logic [DW-1:0]   c_in,
  input  logic [SELW-1:0] a_sel,
  input  logic [SELW-1:0] b_sel,
  input  logic            mem_rd,
  input  logic            dmar_inc,
  input  logic [MDW-1:0]  mem_data,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [DW-1:0]   dm_addr,
  output logic [MDW-1:0]  dm_data,
  output logic            ld_busy
);

  logic [DW-1:0]      regs_q [NREG];
  logic [DW-1:0]      regs_d [NREG];
  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] vld_d;
  logic               ld_busy_q;
  logic               load_ret_s;

  function automatic logic sel_hit(input logic [SELW-1:0] sel, input int idx);
    return sel == SELW'(idx);
  endfunction

  // Load-return valid pipeline: mem_rd enters stage 0; the last stage marks the returning load.
  always_comb begin
    vld_d[0] = mem_rd;
    for (int k = 1; k < MEM_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    load_ret_s = vld_q[MEM_LAT-1];
  end

  // Next state for each register: clear > load return > C write > DMAR increment.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (clr_en && sel_hit(clr_sel, i)) begin
        regs_d[i] = {DW{1'b0}};
      end else if ((i == 1) && load_ret_s) begin
        regs_d[i] = DW'(mem_data);
      end else if (c_en && sel_hit(c_sel, i)) begin
        regs_d[i] = c_in;
      end else if ((i == 0) && dmar_inc) begin
        regs_d[i] = regs_q[i] + DW'(INC_STEP);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // The A and B read ports read the current state; unmapped selects return zero.
  always_comb begin
    a_out = {DW{1'b0}};
    b_out = {DW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      a_out = a_out | (sel_hit(a_sel, i) ? regs_q[i] : {DW{1'b0}});
      b_out = b_out | (sel_hit(b_sel, i) ? regs_q[i] : {DW{1'b0}});
    end
  end

  // State registers; RST also cancels every in-flight load.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
      vld_q     <= {MEM_LAT{1'b0}};
      ld_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      vld_q     <= vld_d;
      ld_busy_q <= |vld_d;
    end
  end

  assign dm_addr = regs_q[0];
  assign dm_data = regs_q[1][MDW-1:0];
  assign ld_busy = ld_busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param with default parameters.
module tb_reg_file_param;

  localparam int DW   = 19;
  localparam int SELW = 4;
  localparam int MDW  = 8;

  logic            clk = 1'b0;
  logic            RST = 1'b1;
  logic            clr_en = 1'b0;
  logic [SELW-1:0] clr_sel = 4'd0;
  logic            c_en = 1'b0;
  logic [SELW-1:0] c_sel = 4'd0;
  logic [DW-1:0]   c_in = 19'h0;
  logic [SELW-1:0] a_sel = 4'd0;
  logic [SELW-1:0] b_sel = 4'd0;
  logic            mem_rd = 1'b0;
  logic            dmar_inc = 1'b0;
  logic [MDW-1:0]  mem_data = 8'h00;
  logic [DW-1:0]   a_out;
  logic [DW-1:0]   b_out;
  logic [DW-1:0]   dm_addr;
  logic [MDW-1:0]  dm_data;
  logic            ld_busy;

  int checks = 0;
  int errors = 0;

  reg_file_param dut (
    .clk(clk), .RST(RST), .clr_en(clr_en), .clr_sel(clr_sel),
    .c_en(c_en), .c_sel(c_sel), .c_in(c_in), .a_sel(a_sel), .b_sel(b_sel),
    .mem_rd(mem_rd), .dmar_inc(dmar_inc), .mem_data(mem_data),
    .a_out(a_out), .b_out(b_out), .dm_addr(dm_addr), .dm_data(dm_data),
    .ld_busy(ld_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            clr_en;
    logic [SELW-1:0] clr_sel;
    logic            c_en;
    logic [SELW-1:0] c_sel;
    logic [DW-1:0]   c_in;
    logic [SELW-1:0] a_sel;
    logic [SELW-1:0] b_sel;
    logic            dmar_inc;
    logic [DW-1:0]   exp_a;
    logic [DW-1:0]   exp_b;
    logic [DW-1:0]   exp_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_en = 1'b0; c_en = 1'b0; mem_rd = 1'b0; dmar_inc = 1'b0;
  endtask

  initial begin
    //            clr  csel  cen  csel   c_in      a     b     inc   exp_a     exp_b     exp_addr
    vecs[0]  = '{1'b0, 4'd0, 1'b1, 4'd5,  19'h2ABCD, 4'd5,  4'd6,  1'b0, 19'h2ABCD, 19'h00000, 19'h00000};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'd0,  19'h7FFFF, 4'd0,  4'd5,  1'b0, 19'h7FFFF, 19'h2ABCD, 19'h7FFFF};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 4'd0,  19'h00000, 4'd0,  4'd5,  1'b1, 19'h00000, 19'h2ABCD, 19'h00000};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd0,  19'h00010, 4'd0,  4'd1,  1'b0, 19'h00010, 19'h00000, 19'h00010};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 4'd0,  19'h00055, 4'd0,  4'd5,  1'b1, 19'h00055, 19'h2ABCD, 19'h00055};
    vecs[5]  = '{1'b1, 4'd5, 1'b1, 4'd7,  19'h01234, 4'd5,  4'd7,  1'b0, 19'h00000, 19'h01234, 19'h00055};
    vecs[6]  = '{1'b1, 4'd7, 1'b1, 4'd7,  19'h00003, 4'd7,  4'd7,  1'b0, 19'h00000, 19'h00000, 19'h00055};
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 4'd15, 19'h7AAAA, 4'd15, 4'd13, 1'b0, 19'h00000, 19'h00000, 19'h00055};
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 4'd13, 19'h00777, 4'd13, 4'd14, 1'b0, 19'h00777, 19'h00000, 19'h00055};
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 4'd0,  19'h00000, 4'd0,  4'd13, 1'b1, 19'h00056, 19'h00777, 19'h00056};
    vecs[10] = '{1'b1, 4'd14, 1'b1, 4'd2, 19'h00001, 4'd13, 4'd2,  1'b0, 19'h00777, 19'h00001, 19'h00056};
    vecs[11] = '{1'b1, 4'd0, 1'b0, 4'd0,  19'h00000, 4'd0,  4'd2,  1'b1, 19'h00000, 19'h00001, 19'h00000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(ld_busy), 32'd0);
    chk("reset_addr", 32'(dm_addr), 32'd0);
    RST = 1'b0;
    tick();

    // Test 1: writes followed by an RST pulse clear everything
    for (int s = 0; s < 14; s++) begin
      c_en = 1'b1; c_sel = SELW'(s); c_in = 19'h1000 + 19'(s);
      tick();
    end
    idle();
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    for (int s = 0; s < 14; s++) begin
      a_sel = SELW'(s); b_sel = SELW'(13 - s);
      #1;
      chk("rst_a", 32'(a_out), 32'd0);
      chk("rst_b", 32'(b_out), 32'd0);
    end
    chk("rst_busy", 32'(ld_busy), 32'd0);
    tick();

    // Table-driven single-cycle vectors; results are checked after the edge
    for (int v = 0; v < 12; v++) begin
      clr_en = vecs[v].clr_en; clr_sel = vecs[v].clr_sel;
      c_en = vecs[v].c_en; c_sel = vecs[v].c_sel; c_in = vecs[v].c_in;
      a_sel = vecs[v].a_sel; b_sel = vecs[v].b_sel; dmar_inc = vecs[v].dmar_inc;
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_a", v), 32'(a_out), 32'(vecs[v].exp_a));
      chk($sformatf("vec%0d_b", v), 32'(b_out), 32'(vecs[v].exp_b));
      chk($sformatf("vec%0d_addr", v), 32'(dm_addr), 32'(vecs[v].exp_addr));
    end

    // Test 2: a write is not visible in the same cycle
    c_en = 1'b1; c_sel = 4'd5; c_in = 19'h15555; a_sel = 4'd5;
    #1;
    chk("no_bypass", 32'(a_out), 32'd0);
    tick();
    idle();
    #1;
    chk("write_next", 32'(a_out), 32'h15555);

    // Test 3b: mem_rd with dmar_inc uses the pre-increment address
    c_en = 1'b1; c_sel = 4'd0; c_in = 19'h00010;
    tick();
    idle();
    mem_rd = 1'b1; dmar_inc = 1'b1;
    #1;
    chk("ld_addr", 32'(dm_addr), 32'h10);
    tick();
    idle();
    #1;
    chk("inc_addr", 32'(dm_addr), 32'h11);
    chk("busy_single", 32'(ld_busy), 32'd1);
    tick();
    mem_data = 8'h5E;
    tick();
    a_sel = 4'd1;
    #1;
    chk("ld_single", 32'(a_out), 32'h0005E);
    chk("busy_single_done", 32'(ld_busy), 32'd0);

    // Test 4: three back-to-back loads return in order
    mem_rd = 1'b1;
    tick();
    chk("b2b_busy0", 32'(ld_busy), 32'd1);
    tick();
    mem_data = 8'hA1;
    tick();
    mem_rd = 1'b0; mem_data = 8'hB2;
    #1;
    chk("b2b_A1", 32'(a_out), 32'h000A1);
    chk("b2b_busy1", 32'(ld_busy), 32'd1);
    tick();
    mem_data = 8'hC3;
    #1;
    chk("b2b_B2", 32'(a_out), 32'h000B2);
    chk("b2b_busy2", 32'(ld_busy), 32'd1);
    tick();
    mem_data = 8'h00;
    #1;
    chk("b2b_C3", 32'(a_out), 32'h000C3);
    chk("b2b_dm_data", 32'(dm_data), 32'hC3);
    chk("b2b_busy_done", 32'(ld_busy), 32'd0);

    // Test 5a: a clear of DMDR beats a returning load
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    tick();
    mem_data = 8'h77; clr_en = 1'b1; clr_sel = 4'd1;
    tick();
    idle();
    #1;
    chk("clr_beats_ld", 32'(a_out), 32'd0);
    chk("clr_busy", 32'(ld_busy), 32'd0);

    // Test 5b: a load beats a C write, while other registers update independently
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    tick();
    mem_data = 8'h3C; c_en = 1'b1; c_sel = 4'd1; c_in = 19'h12345;
    clr_en = 1'b1; clr_sel = 4'd2; dmar_inc = 1'b1; b_sel = 4'd2;
    tick();
    idle();
    #1;
    chk("ld_beats_c", 32'(a_out), 32'h0003C);
    chk("indep_clr", 32'(b_out), 32'd0);
    chk("indep_inc", 32'(dm_addr), 32'h12);

    // Test 6: RST during a load cancels it
    mem_data = 8'hFF; mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    RST = 1'b1;
    #2;
    chk("rst_mid_busy", 32'(ld_busy), 32'd0);
    RST = 1'b0;
    repeat (3) tick();
    chk("rst_mid_dmdr", 32'(dm_data), 32'd0);
    chk("rst_mid_busy_after", 32'(ld_busy), 32'd0);
    c_en = 1'b1; c_sel = 4'd15; c_in = 19'h7FFFF; a_sel = 4'd15;
    tick();
    idle();
    #1;
    chk("sel15_read", 32'(a_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
